// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared sizes, FSM state type and one-hot helper for the 8-way round-robin arbiter.
package rr_arb_pkg;
   localparam int N_REQ = 8;
   localparam int IDX_W = 3;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
      return {{(N_REQ-1){1'b0}}, 1'b1} << i;
   endfunction
endpackage

// File: rtl/rr_arbiter8_pick.sv
// rr_pick8: combinational circular priority search starting at ptr, returns winning index.
module rr_pick8
   import rr_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] win_idx,
   output logic             any_req
);
   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] off;
   // Rotating right puts ptr at bit 0, so the lowest set bit is the circular winner.
   always_comb begin
      rot = N_REQ'({req, req} >> ptr);
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
      win_idx = off + ptr;
      any_req = |req;
   end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with registered one-hot grant and optional hold quantum.
module rr_arbiter8
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             gnt_change
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_ptr, win_idx;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             chg_q, chg_d, rel, any_req;
   rr_pick8 u_pick (
      .req     (req),
      .ptr     (pick_ptr),
      .win_idx (win_idx),
      .any_req (any_req)
   );
   // On release the pointer moves past the holder before the same-cycle re-arbitration.
   always_comb begin
      rel      = state_q == GRANT && (!req[idx_q] || (MAX_HOLD != 0 && hold_q == LAST));
      pick_ptr = rel ? idx_q + 3'd1 : ptr_q;
      state_d  = state_q;
      ptr_d    = ptr_q;
      hold_d   = state_q == GRANT ? hold_q + 1'b1 : '0;
      gnt_d    = gnt_q;
      idx_d    = idx_q;
      chg_d    = 1'b0;
      if (state_q == IDLE ? any_req : rel) begin
         ptr_d   = pick_ptr;
         state_d = any_req ? GRANT : IDLE;
         gnt_d   = any_req ? onehot(win_idx) : '0;
         idx_d   = any_req ? win_idx : '0;
         chg_d   = any_req;
         hold_d  = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         chg_q   <= chg_d;
      end
   end
   assign gnt        = gnt_q;
   assign gnt_idx    = idx_q;
   assign gnt_valid  = |gnt_q;
   assign gnt_change = chg_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed checks of default, MAX_HOLD=1 and MAX_HOLD=4 arbiter instances.
module tb_rr_arbiter8;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [7:0] req_d = '0, req_1 = '0, req_4 = '0;
   logic [7:0] gnt_d, gnt_1, gnt_4;
   logic [2:0] idx_d, idx_1, idx_4;
   logic       val_d, val_1, val_4, chg_d, chg_1, chg_4;
   int         checks = 0, errors = 0;
   always #5 clk = ~clk;
   rr_arbiter8 u_def (
      .clk(clk), .rst_n(rst_n), .req(req_d), .gnt(gnt_d),
      .gnt_idx(idx_d), .gnt_valid(val_d), .gnt_change(chg_d)
   );
   rr_arbiter8 #(.MAX_HOLD(1)) u_h1 (
      .clk(clk), .rst_n(rst_n), .req(req_1), .gnt(gnt_1),
      .gnt_idx(idx_1), .gnt_valid(val_1), .gnt_change(chg_1)
   );
   rr_arbiter8 #(.MAX_HOLD(4)) u_h4 (
      .clk(clk), .rst_n(rst_n), .req(req_4), .gnt(gnt_4),
      .gnt_idx(idx_4), .gnt_valid(val_4), .gnt_change(chg_4)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_d(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v, input logic c);
      chk({tag, " gnt"}, 32'(gnt_d), 32'(g));
      chk({tag, " idx"}, 32'(idx_d), 32'(i));
      chk({tag, " valid"}, 32'(val_d), 32'(v));
      chk({tag, " change"}, 32'(chg_d), 32'(c));
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      repeat (3) step();
      chk_d("in_reset", 8'h00, 3'd0, 1'b0, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_d("idle", 8'h00, 3'd0, 1'b0, 1'b0);
      end
      req_d = 8'h08;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_d("single", 8'h08, 3'd3, 1'b1, i == 0);
      end
      req_d = 8'h00;
      step();
      chk_d("single_drop", 8'h00, 3'd0, 1'b0, 1'b0);
      req_d = 8'h28;
      step();
      chk_d("ptr4", 8'h20, 3'd5, 1'b1, 1'b1);
      req_d = 8'h00;
      step();
      chk_d("ptr4_drop", 8'h00, 3'd0, 1'b0, 1'b0);
      req_d = 8'h05;
      step();
      chk_d("wrap", 8'h01, 3'd0, 1'b1, 1'b1);
      step();
      chk_d("no_preempt", 8'h01, 3'd0, 1'b1, 1'b0);
      req_d = 8'h04;
      step();
      chk_d("b2b", 8'h04, 3'd2, 1'b1, 1'b1);
      step();
      chk_d("b2b_hold", 8'h04, 3'd2, 1'b1, 1'b0);
      req_d = 8'h00;
      step();
      chk_d("b2b_drop", 8'h00, 3'd0, 1'b0, 1'b0);
      req_d = 8'h20;
      step();
      chk_d("pre_rst", 8'h20, 3'd5, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk_d("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      req_d = 8'h22;
      @(negedge clk) rst_n = 1'b1;
      step();
      chk_d("post_rst", 8'h02, 3'd1, 1'b1, 1'b1);
      req_d = 8'h00;
      req_1 = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         step();
         chk($sformatf("rot%0d idx", i), 32'(idx_1), 32'(i % 8));
         chk($sformatf("rot%0d gnt", i), 32'(gnt_1), 32'(8'h01 << (i % 8)));
         chk($sformatf("rot%0d change", i), 32'(chg_1), 32'd1);
      end
      req_1 = 8'h00;
      req_4 = 8'h81;
      for (int i = 0; i < 13; i++) begin
         step();
         chk($sformatf("quant%0d idx", i), 32'(idx_4), (i >= 4 && i < 8) ? 32'd7 : 32'd0);
         chk($sformatf("quant%0d valid", i), 32'(val_4), 32'd1);
         chk($sformatf("quant%0d change", i), 32'(chg_4), 32'(i % 4 == 0));
         if (i == 8) req_4 = 8'h01;
      end
      req_4 = 8'h00;
      step();
      step();
      chk("quant_idle gnt", 32'(gnt_4), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
